superh16_ckpt_ctrl: RTL and testbench

Branch-checkpoint controller for the rename stage: allocates the register alias table's 4 checkpoint slots to in-flight branches in program order and drives the table's create/restore/flush inputs. It retires slots on correct resolution, sequences misprediction recovery with a rename stall, and resets everything on exception flush. It sits between the rename group logic, the branch resolution bus and the alias table.

---
 rtl/superh16_pkg.sv | 21 ++
 rtl/superh16_ckpt_age_mask.sv | 43 ++++
 rtl/superh16_ckpt_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_superh16_ckpt_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/superh16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : superh16_pkg
// Description : Shared sizing constants and the checkpoint-controller state
//               encoding for the rename-stage checkpoint logic.
// Revision    : 1.0 - initial release
// ============================================================================
package superh16_pkg;

    localparam int NUM_CKPT  = 4;
    localparam int CKPT_BITS = $clog2(NUM_CKPT);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RESTORE = 2'd1,
        STALL   = 2'd2,
        FLUSH   = 2'd3
    } ckpt_state_e;

endpackage
`default_nettype wire

// File: rtl/superh16_ckpt_age_mask.sv
`default_nettype none
// ============================================================================
// Module      : superh16_ckpt_age_mask
// Description : Builds the "slot k and every younger slot" squash mask for
//               the checkpoint ring. Age is measured as the ring distance
//               from head; occupied slots lie at offsets 0..occupancy-1.
// Ports       : i_head  - oldest occupied slot
//               i_tail  - next slot to allocate
//               i_k     - mispredicted slot (oldest slot to squash)
//               i_full  - ring fully occupied (head == tail is ambiguous)
//               o_mask  - one bit per slot, 1 = squash
// Revision    : 1.0 - initial release
// ============================================================================
module superh16_ckpt_age_mask #(
    parameter int NUM_CKPT  = 4,
    parameter int CKPT_BITS = $clog2(NUM_CKPT)
) (
    input  logic [CKPT_BITS-1:0] i_head,
    input  logic [CKPT_BITS-1:0] i_tail,
    input  logic [CKPT_BITS-1:0] i_k,
    input  logic                 i_full,
    output logic [NUM_CKPT-1:0]  o_mask
);

    logic [CKPT_BITS-1:0] w_off_k;
    logic [CKPT_BITS-1:0] w_off_tail;
    logic [CKPT_BITS:0]   w_occ;

    assign w_off_k    = i_k - i_head;
    assign w_off_tail = i_tail - i_head;
    // When full, head == tail so the modular distance reads 0; use the size.
    assign w_occ      = i_full ? (CKPT_BITS+1)'(NUM_CKPT) : {1'b0, w_off_tail};

    generate
        for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_slot
            logic [CKPT_BITS-1:0] w_off;
            assign w_off      = CKPT_BITS'(gi) - i_head;
            assign o_mask[gi] = (w_off >= w_off_k) && ({1'b0, w_off} < w_occ);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/superh16_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : superh16_ckpt_ctrl
// Description : Branch-checkpoint controller for the rename stage. Allocates
//               alias-table checkpoint slots in program order, retires them
//               on correct resolution, sequences misprediction recovery with
//               a rename stall and clears everything on exception flush.
// Ports       : clk, rst_n (async, active-low)
//               i_alloc_req / o_alloc_gnt / o_alloc_id  - slot allocation
//               i_resolve_*                             - branch resolution
//               i_flush_req                             - exception flush
//               o_rat_*                                 - alias table control
//               o_rename_stall, o_free_count, o_ckpt_live - status
// Revision    : 1.0 - initial release
// ============================================================================
module superh16_ckpt_ctrl
    import superh16_pkg::*;
#(
    parameter int NUM_CKPT      = superh16_pkg::NUM_CKPT,
    parameter int RECOVER_STALL = 2,
    parameter int CKPT_BITS     = $clog2(NUM_CKPT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_alloc_req,
    output logic                 o_alloc_gnt,
    output logic [CKPT_BITS-1:0] o_alloc_id,
    input  logic                 i_resolve_valid,
    input  logic [CKPT_BITS-1:0] i_resolve_id,
    input  logic                 i_resolve_mispredict,
    input  logic                 i_flush_req,
    output logic                 o_rat_ckpt_create,
    output logic [CKPT_BITS-1:0] o_rat_ckpt_id,
    output logic                 o_rat_ckpt_restore,
    output logic [CKPT_BITS-1:0] o_rat_restore_id,
    output logic                 o_rat_flush,
    output logic                 o_rename_stall,
    output logic [CKPT_BITS:0]   o_free_count,
    output logic [NUM_CKPT-1:0]  o_ckpt_live
);

    localparam logic [CKPT_BITS:0] c_num_ckpt = (CKPT_BITS+1)'(NUM_CKPT);
    localparam logic [2:0]         c_stall    = 3'(RECOVER_STALL);

    ckpt_state_e          r_state;
    logic [2:0]           r_stall_cnt;
    logic                 r_rat_restore;
    logic [CKPT_BITS-1:0] r_restore_id;
    logic                 r_rat_flush;

    logic [CKPT_BITS-1:0] r_head;
    logic [CKPT_BITS-1:0] r_tail;
    logic [CKPT_BITS:0]   r_count;
    logic [NUM_CKPT-1:0]  r_live;

    logic                 w_mispredict;
    logic                 w_correct;
    logic                 w_full;
    logic                 w_gnt;
    logic                 w_head_adv;
    logic [NUM_CKPT-1:0]  w_squash_mask;
    logic [NUM_CKPT-1:0]  w_live_nxt;
    logic [CKPT_BITS-1:0] w_k_dist;

    // Resolves naming a non-live slot were already squashed or retired.
    assign w_mispredict = i_resolve_valid &  i_resolve_mispredict & r_live[i_resolve_id];
    assign w_correct    = i_resolve_valid & ~i_resolve_mispredict & r_live[i_resolve_id];
    assign w_full       = (r_count == c_num_ckpt);
    assign w_gnt        = i_alloc_req & (r_state == RUN) & ~w_full
                        & ~w_mispredict & ~i_flush_req;
    // Resolved slots retire in order, one per cycle, once they reach head.
    assign w_head_adv   = (r_count != '0) & ~r_live[r_head];
    assign w_k_dist     = i_resolve_id - r_head;

    superh16_ckpt_age_mask #(
        .NUM_CKPT  (NUM_CKPT),
        .CKPT_BITS (CKPT_BITS)
    ) u_age_mask (
        .i_head (r_head),
        .i_tail (r_tail),
        .i_k    (i_resolve_id),
        .i_full (w_full),
        .o_mask (w_squash_mask)
    );

    always_comb begin
        w_live_nxt = r_live;
        if (w_correct)
            w_live_nxt[i_resolve_id] = 1'b0;
        if (w_gnt)
            w_live_nxt[r_tail] = 1'b1;
        if (w_mispredict)
            w_live_nxt = w_live_nxt & ~w_squash_mask;
    end

    // Ring pointers, occupancy and live mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_live  <= '0;
        end else if (i_flush_req) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_live  <= '0;
        end else begin
            r_live <= w_live_nxt;
            if (w_head_adv)
                r_head <= r_head + 1'b1;
            if (w_mispredict) begin
                // Head can only advance over a slot older than k, so the
                // surviving occupancy is the distance from the new head.
                r_tail  <= i_resolve_id;
                r_count <= {1'b0, w_k_dist} - {{CKPT_BITS{1'b0}}, w_head_adv};
            end else begin
                if (w_gnt)
                    r_tail <= r_tail + 1'b1;
                r_count <= r_count + {{CKPT_BITS{1'b0}}, w_gnt}
                                   - {{CKPT_BITS{1'b0}}, w_head_adv};
            end
        end
    end

    // Recovery sequencer with registered alias-table controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_stall_cnt   <= '0;
            r_rat_restore <= 1'b0;
            r_restore_id  <= '0;
            r_rat_flush   <= 1'b0;
        end else begin
            r_rat_restore <= 1'b0;
            r_rat_flush   <= 1'b0;
            if (i_flush_req) begin
                r_state     <= FLUSH;
                r_rat_flush <= 1'b1;
            end else if (w_mispredict) begin
                r_state       <= RESTORE;
                r_rat_restore <= 1'b1;
                r_restore_id  <= i_resolve_id;
            end else begin
                case (r_state)
                    RUN: r_state <= RUN;
                    RESTORE: begin
                        if (c_stall == 3'd0) begin
                            r_state <= RUN;
                        end else begin
                            r_state     <= STALL;
                            r_stall_cnt <= c_stall - 3'd1;
                        end
                    end
                    STALL: begin
                        if (r_stall_cnt == 3'd0)
                            r_state <= RUN;
                        else
                            r_stall_cnt <= r_stall_cnt - 3'd1;
                    end
                    FLUSH:   r_state <= RUN;
                    default: r_state <= RUN;
                endcase
            end
        end
    end

    assign o_alloc_gnt        = w_gnt;
    assign o_alloc_id         = r_tail;
    assign o_rat_ckpt_create  = w_gnt;
    assign o_rat_ckpt_id      = r_tail;
    assign o_rat_ckpt_restore = r_rat_restore;
    assign o_rat_restore_id   = r_restore_id;
    assign o_rat_flush        = r_rat_flush;
    assign o_rename_stall     = (r_state != RUN) | (i_alloc_req & ~w_gnt);
    assign o_free_count       = c_num_ckpt - r_count;
    assign o_ckpt_live        = r_live;

endmodule
`default_nettype wire

// File: tb/tb_superh16_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_superh16_ckpt_ctrl
// Description : Directed self-checking bench for superh16_ckpt_ctrl with
//               NUM_CKPT=4 and RECOVER_STALL=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_superh16_ckpt_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_alloc_req;
    logic       o_alloc_gnt;
    logic [1:0] o_alloc_id;
    logic       i_resolve_valid;
    logic [1:0] i_resolve_id;
    logic       i_resolve_mispredict;
    logic       i_flush_req;
    logic       o_rat_ckpt_create;
    logic [1:0] o_rat_ckpt_id;
    logic       o_rat_ckpt_restore;
    logic [1:0] o_rat_restore_id;
    logic       o_rat_flush;
    logic       o_rename_stall;
    logic [2:0] o_free_count;
    logic [3:0] o_ckpt_live;

    int n_checks = 0;
    int n_pass   = 0;

    superh16_ckpt_ctrl #(
        .NUM_CKPT      (4),
        .RECOVER_STALL (2)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_alloc_req          (i_alloc_req),
        .o_alloc_gnt          (o_alloc_gnt),
        .o_alloc_id           (o_alloc_id),
        .i_resolve_valid      (i_resolve_valid),
        .i_resolve_id         (i_resolve_id),
        .i_resolve_mispredict (i_resolve_mispredict),
        .i_flush_req          (i_flush_req),
        .o_rat_ckpt_create    (o_rat_ckpt_create),
        .o_rat_ckpt_id        (o_rat_ckpt_id),
        .o_rat_ckpt_restore   (o_rat_ckpt_restore),
        .o_rat_restore_id     (o_rat_restore_id),
        .o_rat_flush          (o_rat_flush),
        .o_rename_stall       (o_rename_stall),
        .o_free_count         (o_free_count),
        .o_ckpt_live          (o_ckpt_live)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [1:0] id, input logic mp);
        i_resolve_valid      = 1'b1;
        i_resolve_id         = id;
        i_resolve_mispredict = mp;
        tick();
        i_resolve_valid      = 1'b0;
        i_resolve_mispredict = 1'b0;
        #1;
    endtask

    task automatic alloc_one(input string tag, input logic [1:0] exp_id);
        i_alloc_req = 1'b1;
        #1;
        check({tag, "_gnt"}, {31'd0, o_alloc_gnt}, 32'd1);
        check({tag, "_id"}, {30'd0, o_alloc_id}, {30'd0, exp_id});
        tick();
        i_alloc_req = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        i_alloc_req = 1'b0;
        i_resolve_valid = 1'b0;
        i_resolve_id = 2'd0;
        i_resolve_mispredict = 1'b0;
        i_flush_req = 1'b0;
        #12;
        check("rst_gnt",     {31'd0, o_alloc_gnt}, 32'd0);
        check("rst_stall",   {31'd0, o_rename_stall}, 32'd0);
        check("rst_free",    {29'd0, o_free_count}, 32'd4);
        check("rst_live",    {28'd0, o_ckpt_live}, 32'd0);
        check("rst_restore", {31'd0, o_rat_ckpt_restore}, 32'd0);
        check("rst_rid",     {30'd0, o_rat_restore_id}, 32'd0);
        check("rst_flush",   {31'd0, o_rat_flush}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fill the ring back to back.
        for (int i = 0; i < 4; i++) alloc_one("fill", 2'(i));
        check("fill_free", {29'd0, o_free_count}, 32'd0);
        check("fill_live", {28'd0, o_ckpt_live}, 32'hF);
        i_alloc_req = 1'b1;
        #1;
        check("full_gnt",   {31'd0, o_alloc_gnt}, 32'd0);
        check("full_stall", {31'd0, o_rename_stall}, 32'd1);
        i_alloc_req = 1'b0;
        #1;

        // Out-of-order correct resolves retire only in order.
        resolve(2'd2, 1'b0);
        check("res2_live", {28'd0, o_ckpt_live}, 32'hB);
        resolve(2'd0, 1'b0);
        check("res0_free_a", {29'd0, o_free_count}, 32'd0);
        tick();
        check("res0_free_b", {29'd0, o_free_count}, 32'd1);
        tick();
        check("res0_free_c", {29'd0, o_free_count}, 32'd1);
        resolve(2'd1, 1'b0);
        check("res1_live", {28'd0, o_ckpt_live}, 32'h8);
        tick();
        check("res1_free_a", {29'd0, o_free_count}, 32'd2);
        tick();
        check("res1_free_b", {29'd0, o_free_count}, 32'd3);
        tick();
        check("res1_free_c", {29'd0, o_free_count}, 32'd3);

        // Flush with coincident alloc and mispredict on live slot 3.
        i_flush_req = 1'b1;
        i_alloc_req = 1'b1;
        i_resolve_valid = 1'b1;
        i_resolve_id = 2'd3;
        i_resolve_mispredict = 1'b1;
        #1;
        check("fl_gnt",   {31'd0, o_alloc_gnt}, 32'd0);
        check("fl_stall", {31'd0, o_rename_stall}, 32'd1);
        tick();
        i_flush_req = 1'b0;
        i_alloc_req = 1'b0;
        i_resolve_valid = 1'b0;
        i_resolve_mispredict = 1'b0;
        #1;
        check("fl_flush1",  {31'd0, o_rat_flush}, 32'd1);
        check("fl_restore", {31'd0, o_rat_ckpt_restore}, 32'd0);
        check("fl_stall1",  {31'd0, o_rename_stall}, 32'd1);
        check("fl_free",    {29'd0, o_free_count}, 32'd4);
        check("fl_live",    {28'd0, o_ckpt_live}, 32'd0);
        tick();
        check("fl_flush2", {31'd0, o_rat_flush}, 32'd0);
        check("fl_stall2", {31'd0, o_rename_stall}, 32'd0);

        // Mispredict id 1 with slots 0..3 live.
        for (int i = 0; i < 4; i++) alloc_one("mp_fill", 2'(i));
        resolve(2'd1, 1'b1);                     // now in T+1
        check("mp_live",    {28'd0, o_ckpt_live}, 32'h1);
        check("mp_tail",    {30'd0, o_alloc_id}, 32'd1);
        check("mp_free",    {29'd0, o_free_count}, 32'd3);
        check("mp_rest1",   {31'd0, o_rat_ckpt_restore}, 32'd1);
        check("mp_rid",     {30'd0, o_rat_restore_id}, 32'd1);
        i_alloc_req = 1'b1;
        #1;
        check("mp_stall1", {31'd0, o_rename_stall}, 32'd1);
        check("mp_gnt1",   {31'd0, o_alloc_gnt}, 32'd0);
        tick();                                  // T+2
        check("mp_rest2",  {31'd0, o_rat_ckpt_restore}, 32'd0);
        check("mp_stall2", {31'd0, o_rename_stall}, 32'd1);
        tick();                                  // T+3
        check("mp_stall3", {31'd0, o_rename_stall}, 32'd1);
        check("mp_gnt3",   {31'd0, o_alloc_gnt}, 32'd0);
        tick();                                  // T+4
        check("mp_gnt4",   {31'd0, o_alloc_gnt}, 32'd1);
        check("mp_id4",    {30'd0, o_alloc_id}, 32'd1);
        tick();
        i_alloc_req = 1'b0;
        #1;
        check("mp_live4", {28'd0, o_ckpt_live}, 32'h3);

        // Nested mispredict: id 2, then id 0 during STALL.
        alloc_one("nest_a", 2'd2);
        alloc_one("nest_b", 2'd3);
        check("nest_live0", {28'd0, o_ckpt_live}, 32'hF);
        resolve(2'd2, 1'b1);                     // T+1
        check("nest_rid1",  {30'd0, o_rat_restore_id}, 32'd2);
        check("nest_live1", {28'd0, o_ckpt_live}, 32'h3);
        tick();                                  // T+2, STALL
        check("nest_rest2", {31'd0, o_rat_ckpt_restore}, 32'd0);
        resolve(2'd0, 1'b1);
        check("nest_rest3", {31'd0, o_rat_ckpt_restore}, 32'd1);
        check("nest_rid3",  {30'd0, o_rat_restore_id}, 32'd0);
        check("nest_live3", {28'd0, o_ckpt_live}, 32'h0);
        check("nest_free3", {29'd0, o_free_count}, 32'd4);
        check("nest_tail3", {30'd0, o_alloc_id}, 32'd0);
        tick();
        tick();
        check("nest_stall5", {31'd0, o_rename_stall}, 32'd1);
        tick();
        check("nest_stall6", {31'd0, o_rename_stall}, 32'd0);

        // Wrap: move head to 3, allocate 3,0,1, mispredict 0.
        for (int i = 0; i < 3; i++) alloc_one("wr_pre", 2'(i));
        for (int i = 0; i < 3; i++) resolve(2'(i), 1'b0);
        tick();
        tick();
        check("wr_free0", {29'd0, o_free_count}, 32'd4);
        check("wr_tail0", {30'd0, o_alloc_id}, 32'd3);
        alloc_one("wr_a", 2'd3);
        alloc_one("wr_b", 2'd0);
        alloc_one("wr_c", 2'd1);
        check("wr_live", {28'd0, o_ckpt_live}, 32'hB);
        resolve(2'd0, 1'b1);
        check("wr_live_mp", {28'd0, o_ckpt_live}, 32'h8);
        check("wr_tail_mp", {30'd0, o_alloc_id}, 32'd0);
        check("wr_free_mp", {29'd0, o_free_count}, 32'd3);
        check("wr_rest",    {31'd0, o_rat_ckpt_restore}, 32'd1);

        // Asynchronous reset in the middle of recovery.
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_rest",  {31'd0, o_rat_ckpt_restore}, 32'd0);
        check("ar_stall", {31'd0, o_rename_stall}, 32'd0);
        check("ar_free",  {29'd0, o_free_count}, 32'd4);
        check("ar_live",  {28'd0, o_ckpt_live}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
